irq_ctrl: RTL and testbench

//   Parametrised, memory-mapped interrupt controller for the SoC bus.

---
 rtl/irq_ctrl.sv | 127 ++++++++++++
 tb/tb_irq_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl -- memory-mapped interrupt controller, one 16-byte bus slot.
//
// Each src input is a Clk-synchronous event line. A rising edge sets a sticky
// PEND bit. That bit is masked by EN to drive irq_vec, the summary irq, and a
// priority-encoded id in which channel 0 has the highest priority.
//
// Register map (A = addr[3:2]):
//   0 PEND  R/W1C  writing 1 clears a bit; writing 0 has no effect
//   1 EN    R/W
//   2 ID    RO     {irq, zeros, id[ID_W-1:0]}
//   3 RAW   RO     registered copy of src
//
// Optional feature (macro IRQ_CTRL_RD_CLR_EN):
//   Defined   : a read of ID (RE && A==2) while irq is high clears PEND[id].
//   Undefined : reads have no side effects and RE is ignored.
//
// Ports:
//   Clk      in   1     system clock; all state changes on its rising edge
//   Rst      in   1     synchronous, active-high reset
//   src      in   N_CH  event inputs; a rising edge is one event
//   A        in   2     register select
//   WE       in   1     write strobe, asserted for one cycle per write
//   RE       in   1     read strobe (used only by acknowledge-on-read)
//   InData   in   32    write data; bits at or above N_CH are ignored
//   OutData  out  32    read data, combinational on A; unused upper bits are 0
//   irq_vec  out  N_CH  PEND & EN
//   irq      out  1     |irq_vec
// -----------------------------------------------------------------------------
module irq_ctrl #(
  parameter int N_CH = 4,
  parameter int ID_W = 5
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [N_CH-1:0] src,
  input  logic [1:0]      A,
  input  logic            WE,
  input  logic            RE,
  input  logic [31:0]     InData,
  output logic [31:0]     OutData,
  output logic [N_CH-1:0] irq_vec,
  output logic            irq
);

  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_EN   = 2'd1;
  localparam logic [1:0] A_ID   = 2'd2;
  localparam logic [1:0] A_RAW  = 2'd3;

  logic [N_CH-1:0] src_q;
  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] en;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] wr_clr;
  logic [N_CH-1:0] rd_clr;
  logic [ID_W-1:0] id;
  logic            en_wr;

  // One event per low-to-high transition. A line held high does not re-fire.
  assign rise    = src & ~src_q;
  assign wr_clr  = (WE && A == A_PEND) ? InData[N_CH-1:0] : '0;
  assign en_wr   = WE && (A == A_EN);
  assign irq_vec = pend & en;
  assign irq     = |irq_vec;

  // Priority encoder. The loop runs downward, so the lowest set index is the
  // last assignment and wins.
  // NOTE: every always_comb output gets a default first; without it a path
  // that does not assign the output infers a latch.
  always_comb begin
    id = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (irq_vec[i]) id = ID_W'(i);
    end
  end

`ifdef IRQ_CTRL_RD_CLR_EN
  // Acknowledge-on-read: reading ID while irq is high retires the channel
  // whose id the CPU is reading.
  always_comb begin
    rd_clr = '0;
    if (RE && A == A_ID && irq) rd_clr = N_CH'(1) << id;
  end
`else
  assign rd_clr = '0;
`endif

  // RE has no function without acknowledge-on-read. The bits of InData at or
  // above N_CH are don't-care. Both are collected here so they count as used.
  logic unused_ok;
  assign unused_ok = ^{RE, InData};

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples its inputs from before the edge and simulation matches hardware.
  // NOTE: the reset is synchronous and is tested first, so it overrides any
  // write or event in the same cycle. All state is flops, with no RAM.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      src_q <= '0;
      pend  <= '0;
      en    <= '0;
    end else begin
      src_q <= src;
      // OR-ing rise in after the clear means a set wins over a same-cycle
      // clear, so no event is lost.
      pend  <= (pend & ~(wr_clr | rd_clr)) | rise;
      if (en_wr) en <= InData[N_CH-1:0];
    end
  end

  // Read mux. Writes to ID and RAW have no decode above, so they are dropped.
  always_comb begin
    OutData = '0;
    case (A)
      A_PEND: OutData[N_CH-1:0] = pend;
      A_EN:   OutData[N_CH-1:0] = en;
      A_ID: begin
        OutData[31]       = irq;
        OutData[ID_W-1:0] = id;
      end
      A_RAW:  OutData[N_CH-1:0] = src_q;
      default: OutData = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl -- self-checking bench for irq_ctrl with the default parameters
// (N_CH=4, ID_W=5).
//
// A behavioural model tracks PEND, EN and the previous src sample. It applies
// the register rules one channel at a time. The bench first runs the directed
// scenarios and then a randomized phase. After each clock edge it compares
// irq_vec, irq and OutData with the model.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [3:0]  src = '0;
  logic [1:0]  A = '0;
  logic        WE = 1'b0;
  logic        RE = 1'b0;
  logic [31:0] InData = '0;
  wire  [31:0] OutData;
  wire  [3:0]  irq_vec;
  wire         irq;

  irq_ctrl #(.N_CH(4), .ID_W(5)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .src     (src),
    .A       (A),
    .WE      (WE),
    .RE      (RE),
    .InData  (InData),
    .OutData (OutData),
    .irq_vec (irq_vec),
    .irq     (irq)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state.
  bit [3:0] m_src_q = '0;
  bit [3:0] m_pend  = '0;
  bit [3:0] m_en    = '0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Lowest pending-and-enabled channel, or 0 when none is active.
  function automatic int m_id(input bit [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic bit [31:0] exp_rd(input bit [1:0] a);
    bit [3:0] vis = m_pend & m_en;
    case (a)
      2'd0:    return 32'(m_pend);
      2'd1:    return 32'(m_en);
      2'd2:    return {vis != 0, 26'b0, 5'(m_id(vis))};
      default: return 32'(m_src_q);
    endcase
  endfunction

  // One clock: predict the post-edge state from the current inputs, take the
  // edge, then compare the outputs 1 ns later.
  task automatic step();
    bit [3:0] vis = m_pend & m_en;
    bit [3:0] n_pend, n_en;
    int       ack_id;
    bit       ack;
    ack_id = m_id(vis);
`ifdef IRQ_CTRL_RD_CLR_EN
    ack = RE && A == 2'd2 && vis != 0;
`else
    ack = 1'b0;
`endif
    n_en = (WE && A == 2'd1) ? InData[3:0] : m_en;
    for (int i = 0; i < 4; i++) begin
      bit event_i = src[i] && !m_src_q[i];
      bit clr_i   = (WE && A == 2'd0 && InData[i]) || (ack && ack_id == i);
      n_pend[i] = event_i ? 1'b1 : (clr_i ? 1'b0 : m_pend[i]);
    end
    if (Rst) begin
      n_pend = '0;
      n_en   = '0;
    end
    @(posedge Clk);
    m_pend  = n_pend;
    m_en    = n_en;
    m_src_q = Rst ? 4'b0 : src;
    #1;
    check("irq_vec", 32'(irq_vec), 32'(m_pend & m_en));
    check("irq", 32'(irq), 32'((m_pend & m_en) != 0));
    check("rdata", OutData, exp_rd(A));
  endtask

  task automatic wr(input bit [1:0] a, input bit [31:0] d);
    A = a; InData = d; WE = 1'b1;
    step();
    WE = 1'b0;
  endtask

  // Directed read checked against a literal expectation; no clock edge.
  task automatic peek(input bit [1:0] a, input string tag, input bit [31:0] exp);
    A = a;
    #1;
    check(tag, OutData, exp);
  endtask

  task automatic pulse(input bit [3:0] s);
    src = s; step();
    src = '0; step();
  endtask

  initial begin
    // 1: reset, enable all, single pulse on src[2].
    Rst = 1'b1; step(); Rst = 1'b0;
    peek(2'd0, "rst_pend", 32'h0);
    peek(2'd2, "rst_id", 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    wr(2'd1, 32'hF);
    src = 4'h4; step();
    src = 4'h0;
    peek(2'd0, "t1_pend", 32'h4);
    check("t1_irq", 32'(irq), 32'h1);
    peek(2'd2, "t1_id", 32'h8000_0002);

    // 2: held-high source with EN=0 gives exactly one event.
    wr(2'd0, 32'hF);
    wr(2'd1, 32'h0);
    src = 4'h2;
    for (int i = 0; i < 10; i++) step();
    peek(2'd0, "t2_pend", 32'h2);
    check("t2_irq_off", 32'(irq), 32'h0);
    src = 4'h0;
    wr(2'd1, 32'h2);
    check("t2_irq_on", 32'(irq), 32'h1);

    // 3: priority and W1C.
    wr(2'd0, 32'hF);
    wr(2'd1, 32'hF);
    pulse(4'hA);
    peek(2'd2, "t3_id1", 32'h8000_0001);
    wr(2'd0, 32'h2);
    peek(2'd2, "t3_id3", 32'h8000_0003);
    wr(2'd0, 32'h8);
    check("t3_irq", 32'(irq), 32'h0);
    peek(2'd2, "t3_id0", 32'h0);

    // 4: a set in the same cycle as a W1C of that bit wins.
    pulse(4'h1);
    src = 4'h1;
    wr(2'd0, 32'h1);
    src = 4'h0;
    peek(2'd0, "t4_pend", 32'h1);

    // 5: reset discards pending events and overrides a same-cycle write.
    wr(2'd0, 32'hF);
    pulse(4'h5);
    peek(2'd0, "t5_pre", 32'h5);
    Rst = 1'b1; WE = 1'b1; A = 2'd1; InData = 32'hF; src = 4'hF;
    step();
    Rst = 1'b0; WE = 1'b0; src = 4'h0;
    peek(2'd0, "t5_pend", 32'h0);
    peek(2'd1, "t5_en", 32'h0);
    check("t5_irq", 32'(irq), 32'h0);
    wr(2'd1, 32'hF);
    pulse(4'h3);
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd3, 32'hFFFF_FFFF);
    peek(2'd0, "t5_ro_pend", 32'h3);
    peek(2'd1, "t5_ro_en", 32'hF);

    // 6: reading ID with RE.
    wr(2'd0, 32'hF);
    pulse(4'h6);
    peek(2'd2, "t6_id", 32'h8000_0001);
    RE = 1'b1; step(); RE = 1'b0;
`ifdef IRQ_CTRL_RD_CLR_EN
    peek(2'd0, "t6_pend", 32'h4);
    peek(2'd2, "t6_id2", 32'h8000_0002);
`else
    peek(2'd0, "t6_pend", 32'h6);
`endif

    // Randomized phase. src bits toggle with probability 1/4 per cycle, so
    // held levels and fresh edges both occur.
    for (int n = 0; n < 400; n++) begin
      Rst    = ($urandom_range(0, 39) == 0);
      src    = src ^ 4'($urandom & $urandom);
      WE     = ($urandom_range(0, 2) == 0);
      RE     = ($urandom_range(0, 1) == 0);
      A      = 2'($urandom);
      InData = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
